lpgbt_downlink_frame_feeder: RTL and testbench
==============================================

Name: lpgbt_downlink_frame_feeder

Overview:
Transmit-side companion to the lpGBT uplink receive path. Buffers 32-bit user words from fabric logic and presents one word per downlink frame to the lpGBT-FPGA downlink core. Also serialises byte-wide EC and IC side-channel data into the 2-bit-per-frame EC/IC fields. Runs entirely in the 40 MHz frame clock domain; AXI-side control reaches it through CDC synchronisers owned by the wrapper.

Parameters:
DEPTH, 16, user-word FIFO depth in words; power of 2, minimum 4.
START_THRESH, 4, FIFO level required to enter RUN; range 1..DEPTH.
IDLE_WORD, 32'h0000_0000, user word sent when not in RUN or when the FIFO underflows.

Ports:
clk40_i  in  1  40 MHz frame-domain clock.
rst_i  in  1  reset; synchronous, active-high.
frame_strobe_i  in  1  frame clock-enable; one downlink frame per cycle with strobe=1.
enable_i  in  1  enables streaming (control register bit, already synchronised).
downlinkRdy_i  in  1  downlink core ready.
cnt_clr_i  in  1  clears underflow_cnt_o.
s_data_i  in  32  user word in.
s_valid_i  in  1  user word valid.
s_ready_o  out  1  FIFO not full.
ec_byte_i  in  8  EC byte in.
ec_valid_i  in  1  EC byte valid.
ec_ready_o  out  1  EC holding buffer empty.
ic_byte_i  in  8  IC byte in.
ic_valid_i  in  1  IC byte valid.
ic_ready_o  out  1  IC holding buffer empty.
downlinkUserData_o  out  32  frame user data.
downlinkEcData_o  out  2  frame EC bits.
downlinkIcData_o  out  2  frame IC bits.
level_o  out  $clog2(DEPTH)+1  FIFO occupancy.
state_o  out  2  FSM state: 0=DISABLED, 1=WAIT, 2=RUN.
underflow_cnt_o  out  16  frames in RUN with FIFO empty.

Behaviour:
- Reset (clk40_i edge with rst_i=1): FIFO emptied, level_o=0, s_ready_o=0, state=DISABLED, downlinkUserData_o=IDLE_WORD, EC/IC outputs=2'b11, EC/IC buffers and shifters empty, ec_ready_o=ic_ready_o=0, underflow_cnt_o=0. Ready outputs go to 1 on the first cycle after reset is released. Reset mid-stream discards all buffered data.
- FIFO:
  - s_ready_o = !full in every state.
  - Write on s_valid_i&s_ready_o.
  - Read only on a frame_strobe_i cycle while in RUN with FIFO not empty.
  - Simultaneous read and write leaves level unchanged. While full, s_ready_o=0, so a read frees a slot for the next cycle, not the same cycle.
  - No bypass: a word written on a strobe cycle reaches the output at the next strobe at the earliest.
- Outputs are registered. They update only on frame_strobe_i=1 cycles and hold otherwise.
- FSM, evaluated every cycle:
  - DISABLED -> WAIT when enable_i=1.
  - WAIT -> RUN when downlinkRdy_i=1 and level_o>=START_THRESH.
  - RUN -> WAIT when downlinkRdy_i=0.
  - Any state -> DISABLED when enable_i=0; this has priority.
  - In DISABLED and WAIT, strobes output IDLE_WORD.
  - In RUN, a strobe outputs the FIFO head. If the FIFO is empty, it outputs IDLE_WORD and increments underflow_cnt_o.
- underflow_cnt_o:
  - Saturates at 16'hFFFF.
  - cnt_clr_i=1 forces 0. It has priority over a same-cycle increment.
- EC/IC serialisers (identical, independent):
  - Each has a 1-byte holding buffer plus an 8-bit shifter with a 2-bit frame counter.
  - *_ready_o = buffer empty. A byte is accepted on valid&ready.
  - On a strobe with the shifter empty, the buffer moves into the shifter. A byte accepted on that same cycle stays in the buffer.
  - Bits are sent MSB first, 2 per strobe: [7:6], [5:4], [3:2], [1:0]. A byte therefore occupies exactly 4 consecutive strobes.
  - With no data to send, the output is 2'b11 (idle).
  - A back-to-back byte follows with no idle frame.
  - The serialisers run in all FSM states; they are independent of enable_i.

Optional Feature:
LPGBT_DL_PRBS_EN:
- When defined, adds input prbs_sel_i (1 bit).
- In RUN with prbs_sel_i=1, user data comes from a PRBS7 generator (x^7+x^6+1, seed 7'h7F). It advances 32 bits per strobe and the 32-bit word is taken MSB first.
- The FIFO is not read in this mode, and underflow is not counted.
- The generator reseeds on reset and whenever it is not in use.
- When the macro is not defined, the port and the logic are absent.

Test Plan:
- Reset, then enable_i=1, downlinkRdy_i=1, write 4 words 0x11111111..0x44444444, strobe every cycle -> RUN entered the cycle after level=4; outputs 0x11111111..0x44444444 on consecutive strobes, then IDLE_WORD with underflow_cnt_o incrementing 1,2,3.
- Fill 16 words with no strobes -> s_ready_o=0 and level_o=16; one RUN strobe -> level_o=15, s_ready_o=1 the next cycle.
- Drop downlinkRdy_i mid-stream -> state_o=1, IDLE_WORD output, FIFO level frozen; raise it again -> resumes with the next word, no loss.
- EC bytes 0xA5 then 0x3C back-to-back -> EC field sequence 10,10,01,01,00,11,11,00 then 11 idle.
- Hold underflow for 65537 strobes -> underflow_cnt_o=0xFFFF; assert cnt_clr_i together with an underflow strobe -> 0.
- rst_i asserted with 8 words queued and an IC byte mid-shift -> next cycle level_o=0, IC=11, state_o=0; with LPGBT_DL_PRBS_EN and prbs_sel_i=1, the first PRBS word after entering RUN is 0xFE04_1851.

Source files
------------

// File: rtl/lpgbt_downlink_frame_feeder.sv
// lpgbt_downlink_frame_feeder: buffers 32-bit user words and presents one word per downlink
// frame, and serialises byte-wide EC/IC side-channel data two bits per frame.
// Optional feature macro: LPGBT_DL_PRBS_EN (adds prbs_sel_i and a PRBS7 user-data source).
module lpgbt_downlink_frame_feeder #(
    parameter int unsigned DEPTH        = 16,
    parameter int unsigned START_THRESH = 4,
    parameter logic [31:0] IDLE_WORD    = 32'h0000_0000
) (
    input  logic                    clk40_i,
    input  logic                    rst_i,
    input  logic                    frame_strobe_i,
    input  logic                    enable_i,
    input  logic                    downlinkRdy_i,
    input  logic                    cnt_clr_i,
    input  logic [31:0]             s_data_i,
    input  logic                    s_valid_i,
    output logic                    s_ready_o,
    input  logic [7:0]              ec_byte_i,
    input  logic                    ec_valid_i,
    output logic                    ec_ready_o,
    input  logic [7:0]              ic_byte_i,
    input  logic                    ic_valid_i,
    output logic                    ic_ready_o,
`ifdef LPGBT_DL_PRBS_EN
    input  logic                    prbs_sel_i,
`endif
    output logic [31:0]             downlinkUserData_o,
    output logic [1:0]              downlinkEcData_o,
    output logic [1:0]              downlinkIcData_o,
    output logic [$clog2(DEPTH):0]  level_o,
    output logic [1:0]              state_o,
    output logic [15:0]             underflow_cnt_o
);

    localparam int unsigned AW = $clog2(DEPTH);
    localparam logic [AW:0] DEPTH_L  = (AW + 1)'(DEPTH);
    localparam logic [AW:0] THRESH_L = (AW + 1)'(START_THRESH);

    typedef enum logic [1:0] {
        StDisabled = 2'd0,
        StWait     = 2'd1,
        StRun      = 2'd2
    } state_e;

    state_e        state_q;
    logic [31:0]   mem_q [DEPTH];
    logic [AW-1:0] wr_ptr_q, rd_ptr_q;
    logic [AW:0]   count_q;
    logic          rdy_q;
    logic [31:0]   user_q;
    logic [15:0]   ucnt_q;

    logic          full, empty, wr_en, rd_en, underflow, prbs_active;
    logic [31:0]   prbs_word;

    // Serialiser slot 0 carries EC, slot 1 carries IC.
    logic [1:0]    sv_valid, accept;
    logic [7:0]    sv_byte [2];
    logic [7:0]    buf_q [2];
    logic [7:0]    sh_q [2];
    logic [1:0]    sh_cnt_q [2];
    logic [1:0]    bits_q [2];
    logic [1:0]    buf_vld_q, sh_vld_q;

    assign full      = (count_q == DEPTH_L);
    assign empty     = (count_q == '0);
    assign s_ready_o = rdy_q & ~full;
    assign wr_en     = s_valid_i & s_ready_o;
    assign rd_en     = frame_strobe_i & (state_q == StRun) & ~empty & ~prbs_active;
    assign underflow = frame_strobe_i & (state_q == StRun) & empty & ~prbs_active;

    assign sv_valid   = {ic_valid_i, ec_valid_i};
    assign sv_byte[0] = ec_byte_i;
    assign sv_byte[1] = ic_byte_i;
    assign accept     = sv_valid & {rdy_q, rdy_q} & ~buf_vld_q;
    assign ec_ready_o = rdy_q & ~buf_vld_q[0];
    assign ic_ready_o = rdy_q & ~buf_vld_q[1];

    assign downlinkUserData_o = user_q;
    assign downlinkEcData_o   = bits_q[0];
    assign downlinkIcData_o   = bits_q[1];
    assign level_o            = count_q;
    assign state_o            = state_q;
    assign underflow_cnt_o    = ucnt_q;

`ifdef LPGBT_DL_PRBS_EN
    logic [6:0] prbs_q, prbs_s;

    assign prbs_active = (state_q == StRun) & prbs_sel_i;

    // Unroll 32 PRBS7 steps; each output bit is the register MSB before shifting.
    always_comb begin
        prbs_s    = prbs_q;
        prbs_word = '0;
        for (int j = 31; j >= 0; j--) begin
            prbs_word[j] = prbs_s[6];
            prbs_s       = {prbs_s[5:0], prbs_s[6] ^ prbs_s[5]};
        end
    end

    // Generator holds its seed whenever it is not feeding the user field.
    always_ff @(posedge clk40_i) begin
        if (rst_i || !prbs_active) begin
            prbs_q <= 7'h7F;
        end else if (frame_strobe_i) begin
            prbs_q <= prbs_s;
        end
    end
`else
    assign prbs_active = 1'b0;
    assign prbs_word   = IDLE_WORD;
`endif

    // Ready outputs stay low through reset and rise one cycle after release.
    always_ff @(posedge clk40_i) begin
        if (rst_i) rdy_q <= 1'b0;
        else       rdy_q <= 1'b1;
    end

    // FIFO storage; contents need no reset since pointers define validity.
    always_ff @(posedge clk40_i) begin
        if (wr_en) mem_q[wr_ptr_q] <= s_data_i;
    end

    // FIFO pointers and occupancy.
    always_ff @(posedge clk40_i) begin
        if (rst_i) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
        end else begin
            if (wr_en) wr_ptr_q <= wr_ptr_q + AW'(1);
            if (rd_en) rd_ptr_q <= rd_ptr_q + AW'(1);
            if (wr_en && !rd_en)      count_q <= count_q + (AW + 1)'(1);
            else if (!wr_en && rd_en) count_q <= count_q - (AW + 1)'(1);
        end
    end

    // Streaming FSM; losing enable wins over every other transition.
    always_ff @(posedge clk40_i) begin
        if (rst_i || !enable_i) begin
            state_q <= StDisabled;
        end else begin
            unique case (state_q)
                StDisabled: state_q <= StWait;
                StWait:     if (downlinkRdy_i && count_q >= THRESH_L) state_q <= StRun;
                StRun:      if (!downlinkRdy_i) state_q <= StWait;
                default:    state_q <= StDisabled;
            endcase
        end
    end

    // Frame user word and saturating underflow counter.
    always_ff @(posedge clk40_i) begin
        if (rst_i) begin
            user_q <= IDLE_WORD;
            ucnt_q <= '0;
        end else begin
            if (frame_strobe_i) begin
                if (prbs_active) user_q <= prbs_word;
                else if (rd_en)  user_q <= mem_q[rd_ptr_q];
                else             user_q <= IDLE_WORD;
            end
            if (cnt_clr_i)                          ucnt_q <= '0;
            else if (underflow && ucnt_q != 16'hFFFF) ucnt_q <= ucnt_q + 16'd1;
        end
    end

    // EC/IC serialisers: buffer feeds shifter on a strobe that finds the shifter empty,
    // emitting the first pair immediately so back-to-back bytes leave no idle frame.
    always_ff @(posedge clk40_i) begin
        for (int i = 0; i < 2; i++) begin
            if (rst_i) begin
                buf_q[i]     <= '0;
                sh_q[i]      <= '0;
                sh_cnt_q[i]  <= '0;
                bits_q[i]    <= 2'b11;
                buf_vld_q[i] <= 1'b0;
                sh_vld_q[i]  <= 1'b0;
            end else begin
                if (frame_strobe_i) begin
                    if (sh_vld_q[i]) begin
                        bits_q[i]   <= sh_q[i][7:6];
                        sh_q[i]     <= {sh_q[i][5:0], 2'b00};
                        sh_cnt_q[i] <= sh_cnt_q[i] + 2'd1;
                        if (sh_cnt_q[i] == 2'd3) sh_vld_q[i] <= 1'b0;
                    end else if (buf_vld_q[i]) begin
                        bits_q[i]    <= buf_q[i][7:6];
                        sh_q[i]      <= {buf_q[i][5:0], 2'b00};
                        sh_cnt_q[i]  <= 2'd1;
                        sh_vld_q[i]  <= 1'b1;
                        buf_vld_q[i] <= 1'b0;
                    end else begin
                        bits_q[i] <= 2'b11;
                    end
                end
                if (accept[i]) begin
                    buf_q[i]     <= sv_byte[i];
                    buf_vld_q[i] <= 1'b1;
                end
            end
        end
    end

endmodule

// File: tb/tb_lpgbt_downlink_frame_feeder.sv
// Self-checking bench for lpgbt_downlink_frame_feeder: directed scenarios followed by a
// randomized run, all checked against a queue-based behavioural model.
`timescale 1ns/1ps
module tb_lpgbt_downlink_frame_feeder;

    localparam int          DEPTH  = 16;
    localparam int          THRESH = 4;
    localparam logic [31:0] IDLE   = 32'h0000_0000;
    localparam int          LW     = $clog2(DEPTH) + 1;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic          rst, strobe, en, dl_rdy, clr, s_valid, ec_valid, ic_valid;
    logic [31:0]   s_data;
    logic [7:0]    ec_byte, ic_byte;
    logic          s_ready, ec_ready, ic_ready;
    logic [31:0]   user;
    logic [1:0]    ec_bits, ic_bits, state;
    logic [LW-1:0] level;
    logic [15:0]   ucnt;
`ifdef LPGBT_DL_PRBS_EN
    logic          prbs_sel;
`endif

    lpgbt_downlink_frame_feeder #(
        .DEPTH(DEPTH), .START_THRESH(THRESH), .IDLE_WORD(IDLE)
    ) dut (
        .clk40_i(clk), .rst_i(rst), .frame_strobe_i(strobe), .enable_i(en),
        .downlinkRdy_i(dl_rdy), .cnt_clr_i(clr),
        .s_data_i(s_data), .s_valid_i(s_valid), .s_ready_o(s_ready),
        .ec_byte_i(ec_byte), .ec_valid_i(ec_valid), .ec_ready_o(ec_ready),
        .ic_byte_i(ic_byte), .ic_valid_i(ic_valid), .ic_ready_o(ic_ready),
`ifdef LPGBT_DL_PRBS_EN
        .prbs_sel_i(prbs_sel),
`endif
        .downlinkUserData_o(user), .downlinkEcData_o(ec_bits), .downlinkIcData_o(ic_bits),
        .level_o(level), .state_o(state), .underflow_cnt_o(ucnt)
    );

    int unsigned vectors = 0;
    int unsigned miscompares = 0;

    // Behavioural model: FIFO as a queue, serialiser as "byte in flight + pairs left".
    logic [31:0] mq[$];
    int          m_st;
    logic [31:0] m_user;
    logic [15:0] m_ucnt;
    bit          m_rdy;
    bit          m_held [2];
    logic [7:0]  m_hbyte [2];
    logic [7:0]  m_sh [2];
    int          m_left [2];
    logic [1:0]  m_out [2];
    int          m_pos;
    bit          prbs_seq [127];

    function automatic logic [31:0] prbs_at(input int pos);
        logic [31:0] w;
        for (int j = 0; j < 32; j++) w[31-j] = prbs_seq[(pos + j) % 127];
        return w;
    endfunction

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        vectors++;
        assert (obs === exp) else begin
            miscompares++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    task automatic model_edge();
        int         old_size;
        int         old_st;
        bit         wr;
        bit         acc [2];
        bit         sv [2];
        logic [7:0] sb [2];
        bit         prbs_use;
        old_size = mq.size();
        old_st   = m_st;
        sv[0] = ec_valid; sv[1] = ic_valid;
        sb[0] = ec_byte;  sb[1] = ic_byte;
        if (rst) begin
            mq.delete();
            m_st = 0; m_user = IDLE; m_ucnt = '0; m_rdy = 0; m_pos = 0;
            for (int i = 0; i < 2; i++) begin
                m_held[i] = 0; m_left[i] = 0; m_out[i] = 2'b11;
            end
            return;
        end
        wr = s_valid && m_rdy && (old_size < DEPTH);
        for (int i = 0; i < 2; i++) acc[i] = sv[i] && m_rdy && !m_held[i];
        prbs_use = 0;
`ifdef LPGBT_DL_PRBS_EN
        prbs_use = (old_st == 2) && prbs_sel;
`endif
        if (strobe) begin
            if (old_st != 2)        m_user = IDLE;
            else if (prbs_use)      m_user = prbs_at(m_pos);
            else if (old_size > 0)  m_user = mq.pop_front();
            else begin
                m_user = IDLE;
                if (m_ucnt != 16'hFFFF) m_ucnt++;
            end
            for (int i = 0; i < 2; i++) begin
                if (m_left[i] == 0 && m_held[i]) begin
                    m_sh[i] = m_hbyte[i]; m_left[i] = 4; m_held[i] = 0;
                end
                if (m_left[i] > 0) begin
                    m_out[i] = m_sh[i][2*m_left[i]-1 -: 2];
                    m_left[i]--;
                end else begin
                    m_out[i] = 2'b11;
                end
            end
        end
        if (prbs_use) begin
            if (strobe) m_pos = (m_pos + 32) % 127;
        end else begin
            m_pos = 0;
        end
        if (clr) m_ucnt = '0;
        if (wr) mq.push_back(s_data);
        for (int i = 0; i < 2; i++) if (acc[i]) begin m_held[i] = 1; m_hbyte[i] = sb[i]; end
        if (!en)                                           m_st = 0;
        else if (old_st == 0)                              m_st = 1;
        else if (old_st == 1 && dl_rdy && old_size >= THRESH) m_st = 2;
        else if (old_st == 2 && !dl_rdy)                   m_st = 1;
        m_rdy = 1;
    endtask

    task automatic check_all();
        chk("level", 32'(level), 32'(mq.size()));
        chk("state", 32'(state), 32'(m_st));
        chk("s_ready", 32'(s_ready), 32'(m_rdy && mq.size() < DEPTH));
        chk("ec_ready", 32'(ec_ready), 32'(m_rdy && !m_held[0]));
        chk("ic_ready", 32'(ic_ready), 32'(m_rdy && !m_held[1]));
        chk("user", user, m_user);
        chk("ec", 32'(ec_bits), 32'(m_out[0]));
        chk("ic", 32'(ic_bits), 32'(m_out[1]));
        chk("ucnt", 32'(ucnt), 32'(m_ucnt));
    endtask

    task automatic step();
        @(posedge clk);
        model_edge();
        #1;
        check_all();
    endtask

    logic [1:0]  ec_exp [8];
    int          lvl_exp;

    initial begin
        for (int n = 0; n < 127; n++) prbs_seq[n] = (n < 7) ? 1'b1 : (prbs_seq[n-6] ^ prbs_seq[n-7]);
        ec_exp = '{2'b10, 2'b10, 2'b01, 2'b01, 2'b00, 2'b11, 2'b11, 2'b00};
        m_st = 0; m_user = IDLE; m_ucnt = '0; m_rdy = 0; m_pos = 0;
        for (int i = 0; i < 2; i++) begin
            m_held[i] = 0; m_left[i] = 0; m_out[i] = 2'b11; m_sh[i] = '0; m_hbyte[i] = '0;
        end
        rst = 1; strobe = 0; en = 0; dl_rdy = 0; clr = 0; s_valid = 0; s_data = '0;
        ec_valid = 0; ec_byte = '0; ic_valid = 0; ic_byte = '0;
`ifdef LPGBT_DL_PRBS_EN
        prbs_sel = 0;
`endif
        step(); step();
        chk("rst_user", user, IDLE);
        chk("rst_sready", 32'(s_ready), 32'd0);
        chk("rst_ec", 32'(ec_bits), 32'h3);

        // Basic streaming: four words, then underflow.
        rst = 0; en = 1; dl_rdy = 1; strobe = 1;
        step();
        for (int k = 1; k <= 4; k++) begin
            s_valid = 1; s_data = 32'h1111_1111 * k;
            step();
        end
        s_valid = 0;
        step();
        chk("run_entry", 32'(state), 32'd2);
        for (int k = 1; k <= 4; k++) begin
            step();
            chk("stream_word", user, 32'h1111_1111 * k);
        end
        for (int k = 1; k <= 3; k++) begin
            step();
            chk("underflow_idle", user, IDLE);
            chk("underflow_cnt", 32'(ucnt), 32'(k));
        end

        // Fill to full without strobes, then a single read.
        strobe = 0;
        for (int k = 0; k < DEPTH; k++) begin
            s_valid = 1; s_data = 32'hA000_0000 + k;
            step();
        end
        s_valid = 0;
        chk("full_level", 32'(level), 32'd16);
        chk("full_ready", 32'(s_ready), 32'd0);
        strobe = 1;
        step();
        chk("read_level", 32'(level), 32'd15);
        chk("read_ready", 32'(s_ready), 32'd1);

        // Drop downlink ready mid-stream and resume.
        dl_rdy = 0;
        step();
        chk("drop_state", 32'(state), 32'd1);
        lvl_exp = 14;
        for (int k = 0; k < 3; k++) begin
            step();
            chk("drop_idle", user, IDLE);
            chk("drop_level", 32'(level), 32'(lvl_exp));
        end
        dl_rdy = 1;
        step();
        step();
        chk("resume_word", user, 32'hA000_0002);

        // EC back-to-back bytes.
        ec_valid = 1; ec_byte = 8'hA5;
        step();
        ec_byte = 8'h3C;
        step();
        chk("ec_seq", 32'(ec_bits), 32'(ec_exp[0]));
        step();
        chk("ec_seq", 32'(ec_bits), 32'(ec_exp[1]));
        ec_valid = 0;
        for (int k = 2; k < 8; k++) begin
            step();
            chk("ec_seq", 32'(ec_bits), 32'(ec_exp[k]));
        end
        step();
        chk("ec_idle", 32'(ec_bits), 32'h3);

        // Drain, then saturate the underflow counter.
        for (int k = 0; k < 20; k++) step();
        clr = 1;
        step();
        clr = 0;
        for (int k = 0; k < 65537; k++) step();
        chk("ucnt_sat", 32'(ucnt), 32'hFFFF);
        clr = 1;
        step();
        chk("ucnt_clr_prio", 32'(ucnt), 32'd0);
        clr = 0;

        // Reset with words queued and an IC byte mid-shift.
        dl_rdy = 0; strobe = 0;
        step();
        ic_valid = 1; ic_byte = 8'h96;
        for (int k = 0; k < 8; k++) begin
            s_valid = 1; s_data = $urandom;
            step();
            ic_valid = 0;
        end
        s_valid = 0; strobe = 1;
        step();
        step();
        chk("ic_mid", 32'(ic_bits), 32'h1);
        chk("queued", 32'(level), 32'd8);
        rst = 1;
        step();
        chk("rst_level", 32'(level), 32'd0);
        chk("rst_ic", 32'(ic_bits), 32'h3);
        chk("rst_state", 32'(state), 32'd0);
        rst = 0;

`ifdef LPGBT_DL_PRBS_EN
        en = 1; dl_rdy = 1; strobe = 0; prbs_sel = 1;
        step();
        for (int k = 0; k < 4; k++) begin
            s_valid = 1; s_data = $urandom;
            step();
        end
        s_valid = 0;
        step();
        chk("prbs_run", 32'(state), 32'd2);
        strobe = 1;
        step();
        chk("prbs_first", user, 32'hFE04_1851);
        prbs_sel = 0;
`endif

        // Randomized run.
        for (int k = 0; k < 2000; k++) begin
            rst      = ($urandom_range(0, 299) == 0);
            en       = ($urandom_range(0, 31) != 0);
            dl_rdy   = ($urandom_range(0, 15) != 0);
            strobe   = ($urandom_range(0, 1) == 1);
            clr      = ($urandom_range(0, 63) == 0);
            s_valid  = ($urandom_range(0, 2) != 0);
            s_data   = $urandom;
            ec_valid = ($urandom_range(0, 1) == 1);
            ec_byte  = 8'($urandom);
            ic_valid = ($urandom_range(0, 3) == 0);
            ic_byte  = 8'($urandom);
`ifdef LPGBT_DL_PRBS_EN
            prbs_sel = ($urandom_range(0, 3) == 0);
`endif
            step();
        end

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
